// File: rtl/wave_pkg.sv
// Shared encodings and sizes for the wave generator / analyzer pair.
package wave_pkg;

   localparam int unsigned SAMPLE_W             = 8;
   localparam int unsigned COUNT_W              = 9;
   localparam int unsigned WAVE_TIMEOUT_SAMPLES = 256;

   localparam logic [1:0] WAVE_SAW     = 2'b00;
   localparam logic [1:0] WAVE_SQUARE  = 2'b01;
   localparam logic [1:0] WAVE_TRI     = 2'b10;
   localparam logic [1:0] WAVE_UNKNOWN = 2'b11;

   // One period report: recovered frequency setting plus shape code.
   typedef struct packed {
      logic [SAMPLE_W-1:0] freq;
      logic [1:0]          wtype;
   } wave_report_t;

endpackage

// File: rtl/wave_shape_classifier.sv
// Per-period shape tracking; reports the wave type when a period closes.
module wave_shape_classifier
   import wave_pkg::*;
(
   input  logic                Clock,
   input  logic                ResetN,
   input  logic [SAMPLE_W-1:0] sample,
   input  logic [SAMPLE_W-1:0] prev,
   input  logic                clear,
   input  logic                advance,
   output logic [1:0]          wave_type_c
);

   // Triangle phase: start, rising, single flat peak, falling.
   localparam logic [1:0] TRI_START = 2'd0;
   localparam logic [1:0] TRI_UP    = 2'd1;
   localparam logic [1:0] TRI_FLAT  = 2'd2;
   localparam logic [1:0] TRI_DOWN  = 2'd3;

   logic                bin_ok_q, saw_ok_q, tri_ok_q, seen_00_q, seen_ff_q;
   logic                bin_ok_nxt, saw_ok_nxt, tri_ok_nxt, seen_00_nxt, seen_ff_nxt;
   logic [1:0]          tri_phase_q, tri_phase_nxt;
   logic [SAMPLE_W-1:0] delta_c;
   logic                step_up_c, step_flat_c, step_down_c;

   assign delta_c     = sample - prev;
   assign step_up_c   = (delta_c == 8'h01);
   assign step_flat_c = (delta_c == 8'h00);
   assign step_down_c = (delta_c == 8'hFF);

   // Flag update: re-arm on the period-opening sample, fold in each later sample.
   always_comb begin
      bin_ok_nxt    = bin_ok_q;
      saw_ok_nxt    = saw_ok_q;
      tri_ok_nxt    = tri_ok_q;
      seen_00_nxt   = seen_00_q;
      seen_ff_nxt   = seen_ff_q;
      tri_phase_nxt = tri_phase_q;
      if (clear) begin
         bin_ok_nxt    = 1'b1;
         saw_ok_nxt    = 1'b1;
         tri_ok_nxt    = 1'b1;
         seen_00_nxt   = (sample == 8'h00);
         seen_ff_nxt   = (sample == 8'hFF);
         tri_phase_nxt = TRI_START;
      end else if (advance) begin
         bin_ok_nxt  = bin_ok_q & ((sample == 8'h00) | (sample == 8'hFF));
         saw_ok_nxt  = saw_ok_q & step_up_c;
         seen_00_nxt = seen_00_q | (sample == 8'h00);
         seen_ff_nxt = seen_ff_q | (sample == 8'hFF);
         case (tri_phase_q)
            TRI_START: begin
               if (step_up_c) tri_phase_nxt = TRI_UP;
               else           tri_ok_nxt    = 1'b0;
            end
            TRI_UP: begin
               if (step_flat_c)      tri_phase_nxt = TRI_FLAT;
               else if (step_down_c) tri_phase_nxt = TRI_DOWN;
               else if (!step_up_c)  tri_ok_nxt    = 1'b0;
            end
            TRI_FLAT: begin
               if (step_down_c) tri_phase_nxt = TRI_DOWN;
               else             tri_ok_nxt    = 1'b0;
            end
            default: begin
               if (!step_down_c) tri_ok_nxt = 1'b0;
            end
         endcase
      end
   end

   // Flag registers.
   always_ff @(posedge Clock) begin
      if (!ResetN) begin
         bin_ok_q    <= 1'b0;
         saw_ok_q    <= 1'b0;
         tri_ok_q    <= 1'b0;
         seen_00_q   <= 1'b0;
         seen_ff_q   <= 1'b0;
         tri_phase_q <= TRI_START;
      end else begin
         bin_ok_q    <= bin_ok_nxt;
         saw_ok_q    <= saw_ok_nxt;
         tri_ok_q    <= tri_ok_nxt;
         seen_00_q   <= seen_00_nxt;
         seen_ff_q   <= seen_ff_nxt;
         tri_phase_q <= tri_phase_nxt;
      end
   end

   // Priority decode; prev is the period's last sample when the boundary arrives.
   always_comb begin
      wave_type_c = WAVE_UNKNOWN;
      if (bin_ok_q && seen_00_q && seen_ff_q)
         wave_type_c = WAVE_SQUARE;
      else if (saw_ok_q)
         wave_type_c = WAVE_SAW;
      else if (tri_ok_q && (tri_phase_q != TRI_START) && (prev == 8'h01))
         wave_type_c = WAVE_TRI;
   end

endmodule

// File: rtl/wave_analyzer.sv
// Period/shape recovery for the synth sample stream.
// Build option: WAVE_ANALYZER_LOCK_EN enables LOCK_PERIODS-deep lock qualification.
module wave_analyzer
   import wave_pkg::*;
#(
   parameter int unsigned LOCK_PERIODS = 2
)
(
   input  logic                Clock,
   input  logic                ResetN,
   input  logic                SampleValid,
   input  logic [SAMPLE_W-1:0] Waveform,
   output logic [SAMPLE_W-1:0] Frequency,
   output logic [1:0]          WaveType,
   output logic                Locked,
   output logic                Update,
   output logic                Timeout
);

   localparam logic [0:0] SEEK    = 1'b0;
   localparam logic [0:0] MEASURE = 1'b1;

   logic [0:0]          state_q, state_nxt;
   logic [COUNT_W-1:0]  count_q, count_nxt;
   logic [SAMPLE_W-1:0] prev_q, prev_nxt;
   logic [SAMPLE_W-1:0] freq_nxt;
   logic [1:0]          type_nxt;
   logic                locked_nxt, update_nxt, timeout_nxt;
   logic                boundary_c, clear_c, advance_c;
   logic [1:0]          shape_c;
   wave_report_t        rep_c, last_rep_c;

`ifdef WAVE_ANALYZER_LOCK_EN
   localparam int unsigned         MATCH_W  = 4;
   localparam logic [MATCH_W-1:0]  LOCK_TGT = MATCH_W'(LOCK_PERIODS);
   logic [MATCH_W-1:0] match_q, match_nxt;
`else
   logic unused_lock_periods;
   assign unused_lock_periods = ^LOCK_PERIODS;
`endif

   assign boundary_c = (Waveform == 8'h00) && (prev_q != 8'h00);
   assign rep_c      = {SAMPLE_W'(count_q - COUNT_W'(1)), shape_c};
   assign last_rep_c = {Frequency, WaveType};

   wave_shape_classifier u_shape (
      .Clock       (Clock),
      .ResetN      (ResetN),
      .sample      (Waveform),
      .prev        (prev_q),
      .clear       (clear_c),
      .advance     (advance_c),
      .wave_type_c (shape_c)
   );

   // Next-state, period counting, reporting, timeout and lock qualification.
   always_comb begin
      state_nxt   = state_q;
      count_nxt   = count_q;
      prev_nxt    = prev_q;
      freq_nxt    = Frequency;
      type_nxt    = WaveType;
      locked_nxt  = Locked;
      update_nxt  = 1'b0;
      timeout_nxt = 1'b0;
      clear_c     = 1'b0;
      advance_c   = 1'b0;
`ifdef WAVE_ANALYZER_LOCK_EN
      match_nxt   = match_q;
`endif
      if (SampleValid) begin
         prev_nxt = Waveform;
         case (state_q)
            SEEK: begin
               if (boundary_c) begin
                  state_nxt = MEASURE;
                  count_nxt = COUNT_W'(1);
                  clear_c   = 1'b1;
               end
            end
            default: begin
               if (boundary_c) begin
                  freq_nxt   = rep_c.freq;
                  type_nxt   = rep_c.wtype;
                  update_nxt = 1'b1;
                  count_nxt  = COUNT_W'(1);
                  clear_c    = 1'b1;
`ifdef WAVE_ANALYZER_LOCK_EN
                  if ((rep_c.wtype != WAVE_UNKNOWN) && (rep_c == last_rep_c))
                     match_nxt = (match_q >= LOCK_TGT) ? LOCK_TGT : match_q + MATCH_W'(1);
                  else
                     match_nxt = (rep_c.wtype != WAVE_UNKNOWN) ? MATCH_W'(1) : MATCH_W'(0);
                  locked_nxt = (match_nxt == LOCK_TGT);
`else
                  locked_nxt = (rep_c.wtype != WAVE_UNKNOWN);
`endif
               end else if (count_q == COUNT_W'(WAVE_TIMEOUT_SAMPLES)) begin
                  timeout_nxt = 1'b1;
                  freq_nxt    = 8'h00;
                  type_nxt    = WAVE_UNKNOWN;
                  locked_nxt  = 1'b0;
                  state_nxt   = SEEK;
`ifdef WAVE_ANALYZER_LOCK_EN
                  match_nxt   = MATCH_W'(0);
`endif
               end else begin
                  count_nxt = count_q + COUNT_W'(1);
                  advance_c = 1'b1;
               end
            end
         endcase
      end
   end

   // State and output registers.
   always_ff @(posedge Clock) begin
      if (!ResetN) begin
         state_q   <= SEEK;
         count_q   <= '0;
         prev_q    <= 8'h00;
         Frequency <= 8'h00;
         WaveType  <= WAVE_UNKNOWN;
         Locked    <= 1'b0;
         Update    <= 1'b0;
         Timeout   <= 1'b0;
      end else begin
         state_q   <= state_nxt;
         count_q   <= count_nxt;
         prev_q    <= prev_nxt;
         Frequency <= freq_nxt;
         WaveType  <= type_nxt;
         Locked    <= locked_nxt;
         Update    <= update_nxt;
         Timeout   <= timeout_nxt;
      end
   end

`ifdef WAVE_ANALYZER_LOCK_EN
   // Consecutive-match counter.
   always_ff @(posedge Clock) begin
      if (!ResetN) match_q <= '0;
      else         match_q <= match_nxt;
   end
`endif

endmodule

// File: tb/tb_wave_analyzer.sv
// Directed scoreboard bench for wave_analyzer (lock or non-lock build).
module tb_wave_analyzer;
   import wave_pkg::*;

   localparam int LP = 2;

   typedef struct packed {
      logic [7:0] f;
      logic [1:0] t;
      logic       l;
   } exp_t;

   logic       Clock;
   logic       ResetN;
   logic       SampleValid;
   logic [7:0] Waveform;
   logic [7:0] Frequency;
   logic [1:0] WaveType;
   logic       Locked;
   logic       Update;
   logic       Timeout;

   int   n_cmp = 0;
   int   n_fail = 0;
   int   cyc = 0;
   int   last_upd = 0;
   int   upd_gap = 0;
   int   n_timeouts = 0;
   int   exp_timeouts = 0;
   exp_t exp_q[$];

   logic [7:0] tb_prev = 8'h00;
   logic       in_period = 1'b0;
   logic [7:0] pend_f = 8'h00;
   logic [1:0] pend_t = WAVE_UNKNOWN;
   logic       gap = 1'b0;
`ifdef WAVE_ANALYZER_LOCK_EN
   int         m_cnt = 0;
   logic [7:0] m_last_f = 8'h00;
   logic [1:0] m_last_t = WAVE_UNKNOWN;
`endif

   wave_analyzer #(.LOCK_PERIODS(LP)) dut (
      .Clock       (Clock),
      .ResetN      (ResetN),
      .SampleValid (SampleValid),
      .Waveform    (Waveform),
      .Frequency   (Frequency),
      .WaveType    (WaveType),
      .Locked      (Locked),
      .Update      (Update),
      .Timeout     (Timeout)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_lock_model();
`ifdef WAVE_ANALYZER_LOCK_EN
      m_cnt    = 0;
      m_last_f = 8'h00;
      m_last_t = WAVE_UNKNOWN;
`endif
   endtask

   // Expected lock state follows the report history, then the report is queued.
   task automatic push_report(input logic [7:0] f, input logic [1:0] t);
      exp_t e;
      e.f = f;
      e.t = t;
`ifdef WAVE_ANALYZER_LOCK_EN
      if (t != WAVE_UNKNOWN && f == m_last_f && t == m_last_t)
         m_cnt = (m_cnt >= LP) ? LP : m_cnt + 1;
      else
         m_cnt = (t != WAVE_UNKNOWN) ? 1 : 0;
      m_last_f = f;
      m_last_t = t;
      e.l = (m_cnt == LP);
`else
      e.l = (t != WAVE_UNKNOWN);
`endif
      exp_q.push_back(e);
   endtask

   task automatic drive(input logic [7:0] v, input logic valid);
      SampleValid = valid;
      Waveform    = valid ? v : 8'($urandom);
      @(posedge Clock);
      #1;
      if (valid) tb_prev = v;
      if (valid && gap) begin
         SampleValid = 1'b0;
         Waveform    = 8'($urandom);
         @(posedge Clock);
         #1;
      end
   endtask

   // Opening 00 of a period; if it is a boundary it closes the pending period.
   task automatic start_period(input logic [7:0] f, input logic [1:0] t);
      if (tb_prev != 8'h00) begin
         if (in_period) push_report(pend_f, pend_t);
         in_period = 1'b1;
      end
      pend_f = f;
      pend_t = t;
      drive(8'h00, 1'b1);
   endtask

   task automatic saw(input int f, input int n);
      for (int p = 0; p < n; p++) begin
         start_period(8'(f), WAVE_SAW);
         for (int i = 1; i <= f; i++) drive(8'(i), 1'b1);
      end
   endtask

   task automatic square(input int f, input int n);
      for (int p = 0; p < n; p++) begin
         start_period(8'(f), WAVE_SQUARE);
         for (int i = 1; i < (f + 1) / 2; i++) drive(8'h00, 1'b1);
         for (int i = (f + 1) / 2; i <= f; i++) drive(8'hFF, 1'b1);
      end
   endtask

   task automatic tri_wave(input int f, input int peak, input bit flat, input int n);
      for (int p = 0; p < n; p++) begin
         start_period(8'(f), WAVE_TRI);
         for (int i = 1; i <= peak; i++) drive(8'(i), 1'b1);
         if (flat) drive(8'(peak), 1'b1);
         for (int i = peak - 1; i >= 1; i--) drive(8'(i), 1'b1);
      end
   endtask

   task automatic do_reset(input logic [7:0] v);
      ResetN      = 1'b0;
      SampleValid = 1'b1;
      Waveform    = v;
      @(posedge Clock);
      #1;
      ResetN    = 1'b1;
      tb_prev   = 8'h00;
      in_period = 1'b0;
      clear_lock_model();
      chk("reset_outputs", 32'({Frequency, WaveType, Locked, Update, Timeout}),
          32'({8'h00, 2'b11, 3'b000}));
   endtask

   // Output side of the scoreboard, sampled away from the active edge.
   always @(negedge Clock) begin
      exp_t e;
      cyc++;
      if (Update === 1'b1 || Timeout === 1'b1)
         chk("update_timeout_exclusive", 32'(Update & Timeout), 32'd0);
      if (Update === 1'b1) begin
         upd_gap  = cyc - last_upd;
         last_upd = cyc;
         chk("update_expected", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("report_f_type_locked", 32'({Frequency, WaveType, Locked}), 32'(e));
         end
      end
      if (Timeout === 1'b1) begin
         n_timeouts++;
         chk("timeout_outputs", 32'({Frequency, WaveType, Locked}), 32'({8'h00, 2'b11, 1'b0}));
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog expired observed=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      ResetN      = 1'b0;
      SampleValid = 1'b0;
      Waveform    = 8'h00;
      repeat (3) @(posedge Clock);
      #1;
      do_reset(8'h00);

      // F=7 saw: steady reports every 8 cycles
      saw(7, 5);
      chk("saw7_update_gap", 32'(upd_gap), 32'd8);
      chk("saw7_locked", 32'(Locked), 32'd1);

      // square, then both triangle forms
      square(9, 3);
      chk("square9_locked", 32'(Locked), 32'd1);
      tri_wave(6, 3, 1'b1, 3);
      tri_wave(3, 2, 1'b0, 3);

      // frequency change mid-stream
      saw(7, 3);
      saw(12, 3);
      chk("saw12_relocked", 32'({Frequency, Locked}), 32'({8'd12, 1'b1}));

      // flat zero run: one report closes, then one timeout
      start_period(8'h00, WAVE_UNKNOWN);
      in_period = 1'b0;
      clear_lock_model();
      exp_timeouts++;
      for (int i = 0; i < 299; i++) drive(8'h00, 1'b1);
      chk("after_timeout_outputs", 32'({Frequency, WaveType, Locked}), 32'({8'h00, 2'b11, 1'b0}));
      chk("timeout_count", 32'(n_timeouts), 32'(exp_timeouts));

      // relock after SEEK
      saw(7, 4);
      chk("relock_after_timeout", 32'({Frequency, WaveType, Locked}), 32'({8'd7, 2'b00, 1'b1}));

      // half-rate valid
      gap = 1'b1;
      saw(7, 4);
      gap = 1'b0;
      chk("half_rate_update_gap", 32'(upd_gap), 32'd16);

      // reset mid-period, then resume
      start_period(8'd7, WAVE_SAW);
      for (int i = 1; i <= 4; i++) drive(8'(i), 1'b1);
      do_reset(8'h05);
      drive(8'h06, 1'b1);
      drive(8'h07, 1'b1);
      saw(7, 3);

      for (int i = 0; i < 5; i++) drive(8'h00, 1'b0);
      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      chk("final_timeout_count", 32'(n_timeouts), 32'(exp_timeouts));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/wave_analyzer.md
# wave_analyzer

Receive-side companion to the oscillator. It consumes the 8-bit sample stream produced by the synth wave generator, or any source using the same period/shape encoding. For each period it measures the length and recovers the generator's `Frequency` setting (period − 1) and `WaveType` encoding, then asserts `Locked` once the measurement is stable. It sits on the monitor/loopback path so the generator can be self-checked in simulation and on hardware.

## Interface
- `LOCK_PERIODS`, default 2: consecutive identical period reports required before `Locked` asserts (range 1..15).
- `Clock` in 1: sole clock, rising edge.
- `ResetN` in 1: synchronous, active-low reset.
- `SampleValid` in 1: `Waveform` holds a new sample this cycle.
- `Waveform` in 8: sample from the generator.
- `Frequency` out 8: measured period − 1. Reset 8'h00.
- `WaveType` out 2: 00 saw, 01 square, 10 triangle, 11 unknown. Reset 2'b11.
- `Locked` out 1: the last `LOCK_PERIODS` reports matched. Reset 0.
- `Update` out 1: one-cycle pulse when `Frequency`/`WaveType` are refreshed. Reset 0.
- `Timeout` out 1: one-cycle pulse when no boundary is seen for 256 samples. Reset 0.

## Operation
- Only cycles with `SampleValid`=1 are processed; all other cycles leave every register unchanged.
- `Prev` (8 b) holds the last valid sample.
- Reset value of `Prev` is 8'h00.
- **Boundary:** sample == 8'h00 and `Prev` != 8'h00.
- **States:**
  - SEEK: reset state; waits for the first boundary.
  - MEASURE: counting one period.
- **SEEK → MEASURE** on a boundary: `Count`=1, shape flags re-armed, no report.
- **In MEASURE, non-boundary sample:**
  - `Count`++ (9 b, range 1..256).
  - Update the shape flags:
    - `BinOk`: every sample ∈ {00, FF}.
    - `SawOk`: every sample == `Prev`+1 (mod 256).
    - `TriOk`: deltas form a run of ≥1 of +1, then at most one 0, then zero or more −1.
- **In MEASURE, boundary sample:** close the period.
  - Length = `Count`; report F = `Count`−1.
  - Type, by priority:
    - `BinOk` and both 00 and FF seen → 01.
    - Else `SawOk` → 00.
    - Else `TriOk` and last sample == 8'h01 → 10.
    - Else 11.
  - Register F and type, pulse `Update`, then restart with `Count`=1 and flags re-armed.
- **Timeout:** a non-boundary sample arriving with `Count`==256:
  - Pulse `Timeout`.
  - `Frequency`←00, `WaveType`←11, `Locked`←0, match counter cleared.
  - Return to SEEK.
- **Lock:**
  - A report equal to the previous {F, type} with type != 11 increments the match counter, saturating at `LOCK_PERIODS`.
  - Any other report sets the counter to 1 if type != 11, otherwise to 0.
  - `Locked` = (counter == `LOCK_PERIODS`).
  - A mismatched report deasserts `Locked` in the same cycle as its `Update`.
- **Generator F=0:** output is constant 00, so it is undetectable and must end in a timeout.
- **Small-period ambiguity:** F=1 saw and F=1 triangle are the same stream (0,1); this reports 00 by priority.

## Timing
- Outputs are registered.
- Boundary sample accepted at edge k → `Frequency`, `WaveType`, `Locked` and `Update` are valid in the cycle after edge k; latency is 1 clock.
- `Update` and `Timeout` are high for exactly one cycle and are never asserted together.
- The first report arrives one full period after the first boundary. `Locked` first asserts at report number `LOCK_PERIODS`.
- `ResetN`=0 at any edge returns all state to reset values at that edge, regardless of `SampleValid`. Any partial period is discarded.

## Configuration
- `WAVE_ANALYZER_LOCK_EN` defined: lock qualification as above, using `LOCK_PERIODS`.
- Undefined: match counter not built. `Locked` = 1 whenever the most recent report has type != 11. It clears on timeout or reset.

## Structure
- Shared package `wave_pkg` holds:
  - Wave-type encodings `WAVE_SAW`=2'b00, `WAVE_SQUARE`=2'b01, `WAVE_TRI`=2'b10, `WAVE_UNKNOWN`=2'b11.
  - `WAVE_TIMEOUT_SAMPLES`=256.
  - The generator uses the same encodings.
- One sub-module, `wave_shape_classifier`:
  - Holds the per-period `BinOk`, `SawOk` and `TriOk` flags, the triangle phase and the seen-00/seen-FF bits.
  - Inputs: sample, `Prev`, clear, advance. Output: the 2-bit type at boundary.
- The top level holds the SEEK/MEASURE FSM, `Count`, the timeout and the lock logic.

## Test plan
- Generator F=7 saw, continuous valid → first `Update` gives F=7 and type 00 with `Locked`=0. The second `Update` gives `Locked`=1; `Update` then repeats every 8 cycles.
- Square F=9 → F=9, type 01, `Locked` after 2 periods. Stream is 00×5, FF×5.
- Triangle F=6 (stream 0,1,2,3,3,2,1, flat peak) → F=6, type 10. Triangle F=3 (stream 0,1,2,1) → F=3, type 10.
- Saw F changed 7→12 mid-stream → one mismatching report drops `Locked`; `Locked` re-asserts with F=12 two periods later.
- Constant 8'h00 for 300 samples after lock → `Timeout` pulses once; outputs become F=00, type 11, `Locked`=0. SEEK resumes, and normal input relocks.
- `SampleValid` toggled 1/0 on the F=7 saw → identical reports at half rate. `ResetN`=0 mid-period → all outputs at reset values the next cycle, and the first report comes one full period after the next boundary.
